mc_mem_port: RTL and testbench



---
 rtl/mem_pkg.sv | 27 ++
 rtl/mem_array.sv | 43 ++++
 rtl/mc_mem_port.sv | 149 ++++++++++++++
 tb/tb_mc_mem_port.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the mc_mem_port data memory port:
// FSM state encoding, default widths and a constant clog2 helper.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_ADDR_W = 8;

   // Ceiling log2 usable in parameter expressions; clog2(1) = 0.
   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result = result + 1;
         v      = v >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/mem_array.sv
// Word storage for mc_mem_port: synchronous write, registered read.
// The read register is cleared by reset and by the clr strobe, which the
// port raises on write completion (and on a rejected out-of-range access).
module mem_array
   import mem_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = 16,
   parameter int IDX_W  = (DEPTH > 1) ? clog2(DEPTH) : 1
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              we,
   input  logic              re,
   input  logic              clr,
   input  logic [IDX_W-1:0]  addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Storage write port.
   // NOTE: the array has no reset so it maps onto plain RAM; contents survive reset_n.
   always_ff @(posedge clock) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   // Registered read data; holds its value between accesses.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[addr];
      end else if (clr) begin
         rdata <= '0;
      end
   end

endmodule

// File: rtl/mc_mem_port.sv
// Multicycle data memory port: one request at a time over valid/ready,
// LATENCY wait cycles to commit, then a one-cycle response pulse.
// Optional build macro MEM_BOUNDS_CHECK_EN: addresses >= DEPTH are flagged
// with rsp_err, writes are suppressed and reads return 0. Without it the
// address wraps modulo DEPTH and rsp_err is tied low.
module mc_mem_port
   import mem_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DEPTH   = 16,
   parameter int LATENCY = 2
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              req_ready,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              busy
);

   localparam int IDX_W = (DEPTH > 1) ? clog2(DEPTH) : 1;
   localparam int CNT_W = (LATENCY > 1) ? clog2(LATENCY) : 1;

   state_t              state_q;
   state_t              state_d;
   logic [CNT_W-1:0]    cnt_q;
   logic                we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic                commit;
   logic                oob;
   logic                mem_we;
   logic                mem_re;
   logic                mem_clr;

   // FSM state register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and handshake outputs.
   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      state_d   = state_q;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      busy      = 1'b1;
      commit    = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
            if (req_valid) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               commit  = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            state_d   = IDLE;
         end
         default: begin
            busy    = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // Request capture on acceptance and wait-cycle countdown.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (state_q == IDLE && req_valid) begin
         cnt_q   <= CNT_W'(LATENCY - 1);
         we_q    <= req_we;
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
      end else if (state_q == WAIT && cnt_q != '0) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

`ifdef MEM_BOUNDS_CHECK_EN
   logic err_q;

   // Out-of-range test on the full latched address.
   assign oob = ({1'b0, addr_q} >= (ADDR_W + 1)'(DEPTH));

   // Error flag captured at commit, dropped as the response retires.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         err_q <= 1'b0;
      end else if (commit) begin
         err_q <= oob;
      end else if (state_q == RESP) begin
         err_q <= 1'b0;
      end
   end

   assign rsp_err = err_q;
`else
   assign oob     = 1'b0;
   assign rsp_err = 1'b0;

   // Upper address bits are intentionally ignored: the index wraps.
   if (IDX_W < ADDR_W) begin : g_wrap
      logic unused_addr_hi;
      assign unused_addr_hi = ^addr_q[ADDR_W-1:IDX_W];
   end
`endif

   assign mem_we  = commit &  we_q & ~oob;
   assign mem_re  = commit & ~we_q & ~oob;
   assign mem_clr = commit & (we_q | oob);

   mem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_mem (
      .clock   (clock),
      .reset_n (reset_n),
      .we      (mem_we),
      .re      (mem_re),
      .clr     (mem_clr),
      .addr    (addr_q[IDX_W-1:0]),
      .wdata   (wdata_q),
      .rdata   (rsp_rdata)
   );

endmodule

// File: tb/tb_mc_mem_port.sv
// Directed bench for mc_mem_port: a LATENCY=2 instance for the main
// scenarios and a LATENCY=1 instance for the short-latency case.
module tb_mc_mem_port;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        v2, v1;
   logic        we_i;
   logic [7:0]  addr_i;
   logic [15:0] wdata_i;

   logic        ready2, rv2, err2, busy2;
   logic [15:0] rd2;
   logic        ready1, rv1, err1, busy1;
   logic [15:0] rd1;

   int vectors     = 0;
   int miscompares = 0;

`ifdef MEM_BOUNDS_CHECK_EN
   localparam bit BOUNDS = 1'b1;
`else
   localparam bit BOUNDS = 1'b0;
`endif

   always #5 clock = ~clock;

   mc_mem_port #(.DATA_W(16), .ADDR_W(8), .DEPTH(16), .LATENCY(2)) u_l2 (
      .clock     (clock),
      .reset_n   (reset_n),
      .req_valid (v2),
      .req_we    (we_i),
      .req_addr  (addr_i),
      .req_wdata (wdata_i),
      .req_ready (ready2),
      .rsp_valid (rv2),
      .rsp_rdata (rd2),
      .rsp_err   (err2),
      .busy      (busy2)
   );

   mc_mem_port #(.DATA_W(16), .ADDR_W(8), .DEPTH(16), .LATENCY(1)) u_l1 (
      .clock     (clock),
      .reset_n   (reset_n),
      .req_valid (v1),
      .req_we    (we_i),
      .req_addr  (addr_i),
      .req_wdata (wdata_i),
      .req_ready (ready1),
      .rsp_valid (rv1),
      .rsp_rdata (rd1),
      .rsp_err   (err1),
      .busy      (busy1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One complete transaction on the selected instance; returns the response
   // and the number of cycles from the acceptance edge to the response cycle.
   task automatic xact(input bit sel, input logic we, input logic [7:0] addr,
                       input logic [15:0] wd, output logic [15:0] rd,
                       output logic er, output int lat);
      @(negedge clock);
      we_i    = we;
      addr_i  = addr;
      wdata_i = wd;
      if (sel) v1 = 1'b1; else v2 = 1'b1;
      @(negedge clock);
      v1  = 1'b0;
      v2  = 1'b0;
      lat = 0;
      while (((sel ? rv1 : rv2) !== 1'b1) && lat < 20) begin
         @(negedge clock);
         lat++;
      end
      rd = sel ? rd1 : rd2;
      er = sel ? err1 : err2;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [15:0] rd;
      logic        er;
      int          lat;
      int          busy_cnt, rv_cnt, extra, accepted, nrsp;
      logic [15:0] got;
      logic [15:0] resp_d [3];
      int          resp_t [3];
      bit          prev;

      reset_n = 1'b0;
      v2 = 1'b0; v1 = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
      repeat (2) @(negedge clock);
      check("reset_ready", 32'(ready2), 32'h1);
      check("reset_rsp_valid", 32'(rv2), 32'h0);
      check("reset_rdata", 32'(rd2), 32'h0);
      check("reset_err", 32'(err2), 32'h0);
      check("reset_busy", 32'(busy2), 32'h0);
      reset_n = 1'b1;

      // 1: write addr 3 = 00A5, stepped cycle by cycle
      @(negedge clock);
      check("s1_ready_idle", 32'(ready2), 32'h1);
      v2 = 1'b1; we_i = 1'b1; addr_i = 8'd3; wdata_i = 16'h00A5;
      @(negedge clock);
      v2 = 1'b0;
      check("s1_ready_drop", 32'(ready2), 32'h0);
      check("s1_busy", 32'(busy2), 32'h1);
      @(negedge clock);
      check("s1_no_rsp_yet", 32'(rv2), 32'h0);
      @(negedge clock);
      check("s1_rsp_valid", 32'(rv2), 32'h1);
      check("s1_rdata_zero", 32'(rd2), 32'h0);
      @(negedge clock);
      check("s1_rsp_done", 32'(rv2), 32'h0);
      check("s1_ready_back", 32'(ready2), 32'h1);

      // 2: read addr 3; busy spans LATENCY+1 cycles
      v2 = 1'b1; we_i = 1'b0; addr_i = 8'd3;
      @(negedge clock);
      v2 = 1'b0;
      busy_cnt = 0; rv_cnt = 0; got = '0;
      for (int i = 0; i < 6; i++) begin
         if (busy2) busy_cnt++;
         if (rv2) begin rv_cnt++; got = rd2; end
         @(negedge clock);
      end
      check("s2_rdata", 32'(got), 32'h00A5);
      check("s2_rsp_cycles", 32'(rv_cnt), 32'd1);
      check("s2_busy_cycles", 32'(busy_cnt), 32'd3);
      check("s2_rdata_hold", 32'(rd2), 32'h00A5);

      // 3: back-to-back reads with req_valid held high
      xact(1'b0, 1'b1, 8'd0, 16'd5, rd, er, lat);
      xact(1'b0, 1'b1, 8'd1, 16'd9, rd, er, lat);
      xact(1'b0, 1'b1, 8'd2, 16'd12, rd, er, lat);
      check("s3_write_lat", 32'(lat), 32'd2);
      @(negedge clock);
      we_i = 1'b0; addr_i = 8'd0; v2 = 1'b1;
      prev = ready2; accepted = 0; nrsp = 0;
      for (int k = 1; k <= 30 && nrsp < 3; k++) begin
         @(negedge clock);
         if (rv2) begin
            resp_d[nrsp] = rd2;
            resp_t[nrsp] = k;
            nrsp++;
         end
         if (prev) begin
            accepted++;
            if (accepted < 3) addr_i = 8'(accepted); else v2 = 1'b0;
         end
         prev = ready2 & v2;
      end
      v2 = 1'b0;
      extra = 0;
      repeat (6) begin
         @(negedge clock);
         if (rv2) extra++;
      end
      check("s3_num_rsp", 32'(nrsp), 32'd3);
      check("s3_rd0", 32'(resp_d[0]), 32'd5);
      check("s3_rd1", 32'(resp_d[1]), 32'd9);
      check("s3_rd2", 32'(resp_d[2]), 32'd12);
      check("s3_gap01", 32'(resp_t[1] - resp_t[0]), 32'd4);
      check("s3_gap12", 32'(resp_t[2] - resp_t[1]), 32'd4);
      check("s3_no_extra_rsp", 32'(extra), 32'd0);
      check("s3_accepted", 32'(accepted), 32'd3);

      // 4: reset during WAIT drops the write
      xact(1'b0, 1'b1, 8'd7, 16'h0777, rd, er, lat);
      xact(1'b0, 1'b0, 8'd7, 16'h0000, rd, er, lat);
      check("s4_preload_rd", 32'(rd), 32'h0777);
      @(negedge clock);
      v2 = 1'b1; we_i = 1'b1; addr_i = 8'd7; wdata_i = 16'h1234;
      @(negedge clock);
      v2 = 1'b0;
      check("s4_in_wait", 32'(busy2), 32'h1);
      #2 reset_n = 1'b0;
      #1;
      check("s4_rst_busy", 32'(busy2), 32'h0);
      check("s4_rst_ready", 32'(ready2), 32'h1);
      check("s4_rst_rsp_valid", 32'(rv2), 32'h0);
      check("s4_rst_rdata", 32'(rd2), 32'h0);
      @(negedge clock);
      reset_n = 1'b1;
      xact(1'b0, 1'b0, 8'd7, 16'h0000, rd, er, lat);
      check("s4_old_value", 32'(rd), 32'h0777);
      check("s3_read_lat", 32'(lat), 32'd2);

      // 5: LATENCY=1 instance
      xact(1'b1, 1'b1, 8'd2, 16'h00C3, rd, er, lat);
      check("s5_write_lat", 32'(lat), 32'd1);
      xact(1'b1, 1'b0, 8'd2, 16'h0000, rd, er, lat);
      check("s5_read_lat", 32'(lat), 32'd1);
      check("s5_rdata", 32'(rd), 32'h00C3);

      // 6: address 20 against DEPTH=16
      xact(1'b0, 1'b1, 8'd4, 16'h0444, rd, er, lat);
      xact(1'b0, 1'b0, 8'd4, 16'h0000, rd, er, lat);
      check("s6_preload_rd", 32'(rd), 32'h0444);
      xact(1'b0, 1'b1, 8'd20, 16'hBEEF, rd, er, lat);
      check("s6_wr_rdata_clr", 32'(rd), 32'h0);
      check("s6_wr_err", 32'(er), BOUNDS ? 32'h1 : 32'h0);
      check("s6_wr_lat", 32'(lat), 32'd2);
      xact(1'b0, 1'b0, 8'd4, 16'h0000, rd, er, lat);
      check("s6_rd_data", 32'(rd), BOUNDS ? 32'h0444 : 32'hBEEF);
      check("s6_rd_err", 32'(er), 32'h0);
      @(negedge clock);
      check("s6_err_cleared", 32'(err2), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
